mips_instr_encoder: RTL and testbench

//  Inverse of the instruction decoder: takes an instruction select code plus register/immediate

---
 rtl/mips_instr_encoder.sv | 173 +++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: packs a select code plus fields into a 32-bit word and streams it with an address.
// Optional build macro ENC_NOP_PAD_EN appends PAD_NOPS NOP words after the final instruction.
module mips_instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                PAD_NOPS  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_index,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ir,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic              done,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // out_ir/out_addr never change while out_valid is high and out_ready is low.

`ifdef ENC_NOP_PAD_EN
  localparam int PAD_COUNT = PAD_NOPS;
`else
  localparam int PAD_COUNT = 0 * PAD_NOPS;
`endif
  localparam logic [15:0] PAD_LIMIT = 16'(PAD_COUNT);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    F_R     = 3'd0,
    F_SHIFT = 3'd1,
    F_JR    = 3'd2,
    F_I     = 3'd3,
    F_LUI   = 3'd4,
    F_J     = 3'd5,
    F_BAD   = 3'd6
  } fmt_t;

  state_t      state;
  fmt_t        fmt;
  logic [5:0]  code;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        in_fire;
  logic        out_fire;
  logic [15:0] pad_cnt;

  // code is the funct field for R-type formats and the opcode for the rest
  always_comb begin
    fmt  = F_BAD;
    code = 6'h00;
    case (in_op)
      6'd0:  begin fmt = F_R;     code = 6'h20; end
      6'd1:  begin fmt = F_R;     code = 6'h21; end
      6'd2:  begin fmt = F_R;     code = 6'h22; end
      6'd3:  begin fmt = F_R;     code = 6'h23; end
      6'd4:  begin fmt = F_R;     code = 6'h24; end
      6'd5:  begin fmt = F_R;     code = 6'h25; end
      6'd6:  begin fmt = F_R;     code = 6'h26; end
      6'd7:  begin fmt = F_R;     code = 6'h27; end
      6'd8:  begin fmt = F_R;     code = 6'h2A; end
      6'd9:  begin fmt = F_R;     code = 6'h2B; end
      6'd10: begin fmt = F_SHIFT; code = 6'h00; end
      6'd11: begin fmt = F_SHIFT; code = 6'h02; end
      6'd12: begin fmt = F_SHIFT; code = 6'h03; end
      6'd13: begin fmt = F_R;     code = 6'h04; end
      6'd14: begin fmt = F_R;     code = 6'h06; end
      6'd15: begin fmt = F_R;     code = 6'h07; end
      6'd16: begin fmt = F_JR;    code = 6'h08; end
      6'd17: begin fmt = F_I;     code = 6'h08; end
      6'd18: begin fmt = F_I;     code = 6'h09; end
      6'd19: begin fmt = F_I;     code = 6'h0C; end
      6'd20: begin fmt = F_I;     code = 6'h0D; end
      6'd21: begin fmt = F_I;     code = 6'h0E; end
      6'd22: begin fmt = F_I;     code = 6'h23; end
      6'd23: begin fmt = F_I;     code = 6'h2B; end
      6'd24: begin fmt = F_I;     code = 6'h04; end
      6'd25: begin fmt = F_I;     code = 6'h05; end
      6'd26: begin fmt = F_I;     code = 6'h0A; end
      6'd27: begin fmt = F_I;     code = 6'h0B; end
      6'd28: begin fmt = F_LUI;   code = 6'h0F; end
      6'd29: begin fmt = F_J;     code = 6'h02; end
      6'd30: begin fmt = F_J;     code = 6'h03; end
      default: begin fmt = F_BAD; code = 6'h00; end
    endcase
  end

  always_comb begin
    enc_word = 32'h0;
    case (fmt)
      F_R:     enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, code};
      F_SHIFT: enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, code};
      F_JR:    enc_word = {6'h00, in_rs, 15'd0, code};
      F_I:     enc_word = {code, in_rs, in_rt, in_imm};
      F_LUI:   enc_word = {code, 5'd0, in_rt, in_imm};
      F_J:     enc_word = {code, in_index};
      default: enc_word = 32'h0;
    endcase
  end

  assign enc_illegal = (fmt == F_BAD);
  assign in_ready    = (state == RUN) && (!out_valid || out_ready);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      out_valid   <= 1'b0;
      out_ir      <= 32'h0;
      out_addr    <= BASE_ADDR;
      err_illegal <= 1'b0;
      done        <= 1'b0;
      pad_cnt     <= 16'h0;
    end else begin
      err_illegal <= in_fire && enc_illegal;
      if (out_fire) begin
        out_addr <= out_addr + ADDR_W'(1);
      end
      case (state)
        RUN: begin
          if (in_fire && !enc_illegal) begin
            out_valid <= 1'b1;
            out_ir    <= enc_word;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (in_fire && in_last) begin
            state   <= DRAIN;
            pad_cnt <= 16'h0;
          end
        end
        DRAIN: begin
          // NOP padding reloads behind the draining word without a bubble
          if ((pad_cnt != PAD_LIMIT) && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_ir    <= 32'h0;
            pad_cnt   <= pad_cnt + 16'(1);
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end else if (!out_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with hand-computed words, a small-address wrap and end-of-program checks.
module tb_mips_instr_encoder;

  localparam int ADDR_W = 2;
`ifdef ENC_NOP_PAD_EN
  localparam int EXP_PADS = 2;
`else
  localparam int EXP_PADS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_index;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ir;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic              done;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic [31:0]       held_ir;
  int                pads;
  int                cyc;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0), .PAD_NOPS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_index(in_index), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_addr(out_addr),
    .err_illegal(err_illegal), .done(done), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] idx, input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_shamt = sh;
    in_imm   = imm;
    in_index = idx;
    in_last  = last;
  endtask

  // One accepted word with out_ready high: it must appear one cycle later at the model address.
  task automatic stream_step(input string tag, input logic [5:0] op, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [25:0] idx, input logic last,
                             input logic [31:0] word);
    logic [31:0] e;
    set_in(op, rs, rt, rd, sh, imm, idx, last);
    exp_q.push_back(word);
    tick();
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_ir"}, out_ir, e);
    check({tag, "_addr"}, {30'd0, out_addr}, {30'd0, exp_addr});
    exp_addr = exp_addr + 2'd1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_index = '0; in_last = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_ir", out_ir, 32'h0);
    check("rst_out_addr", {30'd0, out_addr}, 32'd0);
    check("rst_err", {31'd0, err_illegal}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    exp_addr  = '0;
    out_ready = 1'b1;
    stream_step("add", 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h00221820);
    in_valid = 1'b0;
    tick();
    check("add_drained", {31'd0, out_valid}, 32'd0);
    check("add_addr_inc", {30'd0, out_addr}, 32'd1);

    stream_step("sll", 6'd10, 5'd5, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0, 32'h00011100);
    in_valid = 1'b0;
    tick();

    // Sink stalls for three cycles
    out_ready = 1'b0;
    set_in(6'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_ir", out_ir, 32'h20220005);
    check("addi_addr", {30'd0, out_addr}, 32'd2);
    held_ir = 32'h20220005;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ir", out_ir, held_ir);
      check("stall_addr", {30'd0, out_addr}, 32'd2);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("stall_release_valid", {31'd0, out_valid}, 32'd0);
    check("stall_release_addr", {30'd0, out_addr}, 32'd3);
    exp_addr = 2'd3;

    // Illegal select code
    set_in(6'd40, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("ill_err", {31'd0, err_illegal}, 32'd1);
    check("ill_no_valid", {31'd0, out_valid}, 32'd0);
    check("ill_addr", {30'd0, out_addr}, 32'd3);
    tick();
    check("ill_err_pulse", {31'd0, err_illegal}, 32'd0);
    check("ill_addr_hold", {30'd0, out_addr}, 32'd3);

    // Back-to-back stream crossing the address wrap, ending with in_last
    stream_step("lui",   6'd28, 5'd7,  5'd1,  5'd0,  5'd0,  16'h1234, 26'h0, 1'b0, 32'h3C011234);
    stream_step("ori",   6'd20, 5'd3,  5'd4,  5'd9,  5'd1,  16'h00FF, 26'h0, 1'b0, 32'h346400FF);
    stream_step("beq",   6'd24, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFE, 26'h0, 1'b0, 32'h1022FFFE);
    stream_step("sw",    6'd23, 5'd29, 5'd31, 5'd0,  5'd0,  16'h0008, 26'h0, 1'b0, 32'hAFBF0008);
    stream_step("jr",    6'd16, 5'd31, 5'd7,  5'd9,  5'd3,  16'h0,    26'h0, 1'b0, 32'h03E00008);
    stream_step("jal",   6'd30, 5'd0,  5'd0,  5'd31, 5'd0,  16'h0,    26'h3FFFFFF, 1'b0, 32'h0FFFFFFF);
    stream_step("sub",   6'd2,  5'd4,  5'd5,  5'd6,  5'd7,  16'h0,    26'h0, 1'b0, 32'h00853022);
    stream_step("sra",   6'd12, 5'd3,  5'd8,  5'd9,  5'd31, 16'h0,    26'h0, 1'b0, 32'h00084FC3);
    stream_step("nor",   6'd7,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0,    26'h0, 1'b0, 32'h00221827);
    stream_step("sltiu", 6'd27, 5'd2,  5'd3,  5'd0,  5'd0,  16'h8000, 26'h0, 1'b0, 32'h2C438000);
    stream_step("j",     6'd29, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0,    26'h10, 1'b1, 32'h08000010);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("drain_in_ready", {31'd0, in_ready}, 32'd0);

    pads = 0;
    cyc  = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      if (out_valid) begin
        check("pad_ir", out_ir, 32'h0);
        check("pad_addr", {30'd0, out_addr}, {30'd0, exp_addr});
        exp_addr = exp_addr + 2'd1;
        pads++;
      end
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("pad_count", pads, EXP_PADS);
    check("done_state", {30'd0, fsm_state}, 32'd2);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    set_in(6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    tick();
    in_valid = 1'b0;
    check("done_held", {31'd0, done}, 32'd1);
    check("done_no_word", {31'd0, out_valid}, 32'd0);

    // Reset with a pending word
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    set_in(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("pend_valid", {31'd0, out_valid}, 32'd1);
    check("pend_addr", {30'd0, out_addr}, 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ir", out_ir, 32'h0);
    check("mid_rst_addr", {30'd0, out_addr}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
